// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: DATA_W-bit beat loader into a CHAIN_LEN-bit config chain.
// Define CFG_CRC_EN to add a CRC-8 (poly 0x07) trailer check after the payload.
module fpga_cfg_loader #(
  parameter int DATA_W    = 4,
  parameter int CHAIN_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 cfg_start,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [CHAIN_LEN-1:0] cfg_bits,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err
);
  localparam int BEATS = CHAIN_LEN / DATA_W;
  localparam int CNT_W = $clog2(BEATS + 1);
`ifdef CFG_CRC_EN
  typedef enum logic [2:0] {IDLE, LOAD, CRC, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERR} state_t;
`endif
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             last;
`ifdef CFG_CRC_EN
  logic [7:0] crc;
  logic [7:0] trl;
  logic [7:0] trl_n;
  logic [3:0] tcnt;
  logic       tlast;
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [DATA_W-1:0] d);
    logic [7:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction
  assign cfg_busy = (state == LOAD) | (state == CRC);
  assign trl_n    = 8'({trl, cfg_data});
  assign tlast    = tcnt == 4'(8 / DATA_W - 1);
`else
  assign cfg_busy = state == LOAD;
  assign cfg_err  = 1'b0;
`endif
  assign cfg_ready = ena & cfg_busy;
  // a start pulse in the same cycle as a beat discards the beat
  assign acc  = cfg_valid & cfg_ready & ~cfg_start;
  assign last = cnt == CNT_W'(BEATS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg_bits <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
`ifdef CFG_CRC_EN
      crc      <= 8'h00;
      trl      <= 8'h00;
      tcnt     <= 4'd0;
      cfg_err  <= 1'b0;
`endif
    end else if (ena && cfg_start) begin
      state    <= LOAD;
      cnt      <= '0;
      cfg_done <= 1'b0;
`ifdef CFG_CRC_EN
      crc      <= 8'h00;
      tcnt     <= 4'd0;
      cfg_err  <= 1'b0;
`endif
    end else if (acc && state == LOAD) begin
      cfg_bits <= CHAIN_LEN'({cfg_bits, cfg_data});
      cnt      <= last ? '0 : cnt + CNT_W'(1);
`ifdef CFG_CRC_EN
      crc      <= crc_step(crc, cfg_data);
      if (last) state <= CRC;
`else
      if (last) begin
        state    <= DONE;
        cfg_done <= 1'b1;
      end
`endif
    end
`ifdef CFG_CRC_EN
    else if (acc && state == CRC) begin
      trl  <= trl_n;
      tcnt <= tcnt + 4'd1;
      if (tlast) begin
        state    <= (trl_n == crc) ? DONE : ERR;
        cfg_done <= trl_n == crc;
        cfg_err  <= trl_n != crc;
      end
    end
`endif
  end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed load scenarios checked every cycle against a beat-queue model.
module tb_fpga_cfg_loader;
  localparam int DW = 4;
  localparam int CL = 16;
  localparam int BEATS = CL / DW;
  localparam int TBEATS = 8 / DW;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          cfg_start = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CL-1:0] cfg_bits;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit       m_act = 1'b0;
  int       nb = 0;
  int       nt = 0;
  logic [15:0] mb = '0;
  logic [7:0]  mt = '0;
  bit       m_done = 1'b0;
  bit       m_err = 1'b0;

  fpga_cfg_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bits(cfg_bits), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // remainder of payload * x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_of(input logic [15:0] m);
    logic [23:0] r;
    r = {m, 8'h00};
    for (int i = 23; i >= 8; i--) if (r[i]) r = r ^ (24'h107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_act = 0; nb = 0; nt = 0; mb = '0; mt = '0; m_done = 0; m_err = 0;
  endtask

  task automatic cyc(input bit st, input bit v, input logic [DW-1:0] d, input bit e);
    bit take;
    cfg_start = st; cfg_valid = v; cfg_data = d; ena = e;
    take = e && m_act && v && !st;
    @(posedge clk);
    if (e && st) begin
      m_act = 1; nb = 0; nt = 0; mt = '0; m_done = 0; m_err = 0;
    end else if (take) begin
      if (nb < BEATS) begin
        mb = {mb[11:0], d};
        nb++;
`ifndef CFG_CRC_EN
        if (nb == BEATS) begin m_act = 0; m_done = 1; end
`endif
      end else begin
        mt = {mt[3:0], d};
        nt++;
        if (nt == TBEATS) begin
          m_act = 0;
          m_done = (mt == crc_of(mb));
          m_err = !m_done;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 1);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    cyc(0, 1, d, 1);
  endtask

  task automatic trailer(input logic [7:0] t);
`ifdef CFG_CRC_EN
    beat(t[7:4]);
    beat(t[3:0]);
`else
    if (t === 8'hxx) $display("unused trailer");
`endif
  endtask

  always @(negedge clk) if (chk_en) begin
    check("bits", 32'(cfg_bits), 32'(mb));
    check("ready", 32'(cfg_ready), 32'(ena && m_act));
    check("busy", 32'(cfg_busy), 32'(m_act));
    check("done", 32'(cfg_done), 32'(m_done));
    check("err", 32'(cfg_err), 32'(m_err));
    check("done_err_excl", 32'(cfg_done & cfg_err), 32'd0);
  end

  initial begin
    #12;
    check("rst_bits", 32'(cfg_bits), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    // 1: back-to-back load
    cyc(1, 0, '0, 1);
    beat(4'hA); beat(4'hB); beat(4'hC); beat(4'hD);
    trailer(8'hE2);
    check("t1_bits", 32'(cfg_bits), 32'h0000ABCD);
    check("t1_model_bits", 32'(mb), 32'h0000ABCD);
    check("t1_done", 32'(cfg_done), 32'd1);
    check("t1_busy", 32'(cfg_busy), 32'd0);
    check("t1_ready", 32'(cfg_ready), 32'd0);
    idle(2);
    // 2: valid gaps, ena low for 3 cycles with a start pulse that must be ignored
    cyc(1, 0, '0, 1);
    beat(4'hA); cyc(0, 0, 4'h7, 1); beat(4'hB);
    cyc(0, 1, 4'hF, 0); cyc(1, 1, 4'hF, 0); cyc(0, 1, 4'hF, 0);
    cyc(0, 0, '0, 1); beat(4'hC); cyc(0, 0, '0, 1); beat(4'hD);
    trailer(8'hE2);
    check("t2_bits", 32'(cfg_bits), 32'h0000ABCD);
    check("t2_done", 32'(cfg_done), 32'd1);
    // 3: restart mid-load; the restart cycle carries a beat that is discarded
    cyc(1, 0, '0, 1);
    beat(4'h5); beat(4'h6);
    cyc(1, 1, 4'h9, 1);
    beat(4'h1); beat(4'h2); beat(4'h3);
    check("t3_not_done", 32'(cfg_done), 32'd0);
    beat(4'h4);
    trailer(crc_of(16'h1234));
    check("t3_bits", 32'(cfg_bits), 32'h00001234);
    check("t3_done", 32'(cfg_done), 32'd1);
    // 4: reset mid-load
    cyc(1, 0, '0, 1);
    beat(4'h8); beat(4'h9); beat(4'h7);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t4_bits", 32'(cfg_bits), 32'd0);
    check("t4_busy", 32'(cfg_busy), 32'd0);
    check("t4_ready", 32'(cfg_ready), 32'd0);
    check("t4_done", 32'(cfg_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 1, 4'h6, 1);
    idle(2);
    check("t4_no_done", 32'(cfg_done), 32'd0);
    // 5: beats after done are ignored
    cyc(1, 0, '0, 1);
    beat(4'hA); beat(4'hB); beat(4'hC); beat(4'hD);
    trailer(8'hE2);
    beat(4'h3); beat(4'h4);
    check("t5_bits", 32'(cfg_bits), 32'h0000ABCD);
    check("t5_ready", 32'(cfg_ready), 32'd0);
    check("t5_done", 32'(cfg_done), 32'd1);
`ifdef CFG_CRC_EN
    // 6: corrupted trailer
    check("t6_model_crc", 32'(crc_of(mb)), 32'h000000E2);
    cyc(1, 0, '0, 1);
    beat(4'hA); beat(4'hB); beat(4'hC); beat(4'hD);
    trailer(8'hE3);
    check("t6_err", 32'(cfg_err), 32'd1);
    check("t6_done", 32'(cfg_done), 32'd0);
    cyc(1, 0, '0, 1);
    check("t6_err_clr", 32'(cfg_err), 32'd0);
    beat(4'hA); beat(4'hB); beat(4'hC); beat(4'hD);
    trailer(8'hE2);
    check("t6_ok_done", 32'(cfg_done), 32'd1);
    check("t6_ok_err", 32'(cfg_err), 32'd0);
`endif
    idle(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
